// File: rtl/appmsg_feed_ctrl_pkg.sv
// Shared definitions for the APP message feed sequencer: FSM encodings,
// frame lengths, blocks per decoder and the sub-block index helper.
package appmsg_feed_ctrl_pkg;

    typedef enum logic [2:0] {
        FEED_IDLE   = 3'd0,
        FEED_ARM    = 3'd1,
        FEED_PRE    = 3'd2,
        FEED_STREAM = 3'd3,
        FEED_GAP    = 3'd4
    } feed_state_t;

    localparam int LEN_R23             = 176;
    localparam int LEN_R78             = 48;
    localparam int BLK_NUM_PER_DECODER = 8;

    localparam logic [2:0] ILS_R23 = 3'd1;
    localparam logic [2:0] ILS_R78 = 3'd2;

    // Sub-block index of a beat; everything past the third short block is block 3.
    function automatic logic [1:0] sub_idx(input logic [7:0] beat, input int sub_len);
        int q;
        q = int'(beat) / sub_len;
        return (q > 3) ? 2'd3 : q[1:0];
    endfunction

endpackage

// File: rtl/appmsg_feed_ctrl_beat_gen.sv
// Beat counter, sub-block index and ROM address lookahead for one frame.
// All frame strobes are registered one cycle behind the internal beat count.
module feed_beat_gen
    import appmsg_feed_ctrl_pkg::*;
#(
    parameter int SUB_LEN = 16,
    parameter int ADDR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [7:0]        last_beat,
    output logic              final_beat,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              buffer_valid,
    output logic              buffer_start,
    output logic              buffer_last,
    output logic [1:0]        sub_x
);

    logic [7:0]        beat_q, beat_d;
    logic [7:0]        next_beat;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              valid_q, valid_d;
    logic              start_q, start_d;
    logic              last_q, last_d;
    logic [1:0]        sub_x_q, sub_x_d;

    always_comb begin
        final_beat = run && (beat_q == last_beat);
        next_beat  = beat_q + 8'd1;
        beat_d     = (run && !final_beat) ? next_beat : 8'd0;
        valid_d    = run;
        start_d    = run && (beat_q == 8'd0);
        last_d     = final_beat;
        sub_x_d    = run ? sub_idx(beat_q, SUB_LEN) : 2'd0;
        // Address leads data by one cycle, so it selects the block of the next beat.
        rom_addr_d = (run && !final_beat) ? ADDR_W'(sub_idx(next_beat, SUB_LEN)) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q     <= 8'd0;
            rom_addr_q <= '0;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            last_q     <= 1'b0;
            sub_x_q    <= 2'd0;
        end else begin
            beat_q     <= beat_d;
            rom_addr_q <= rom_addr_d;
            valid_q    <= valid_d;
            start_q    <= start_d;
            last_q     <= last_d;
            sub_x_q    <= sub_x_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign buffer_valid = valid_q;
    assign buffer_start = start_q;
    assign buffer_last  = last_q;
    assign sub_x        = sub_x_q;

endmodule

// File: rtl/appmsg_feed_ctrl.sv
// Frame sequencer feeding initial APP sub-blocks from the lane ROMs into LDPC_Dec.
// Define APPMSG_FEED_FRAMECNT_EN to build the frames_sent counter.
module appmsg_feed_ctrl
    import appmsg_feed_ctrl_pkg::*;
#(
    parameter int SUB_LEN  = LEN_R78 / 3,
    parameter int LONG_LEN = LEN_R23 - LEN_R78,
    parameter int BLK_NUM  = BLK_NUM_PER_DECODER,
    parameter int ADDR_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [2:0]        iLs,
    input  logic              buffer_ready,
    input  logic [2:0]        decode_valid_cnt,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              buffer_valid,
    output logic              buffer_start,
    output logic              buffer_last,
    output logic [1:0]        APPmsg_ini_sub_x,
    output logic              all_done,
    output logic [7:0]        frames_sent
);

    feed_state_t state_q;
    logic [2:0]  ils_q;
    logic        all_done_q, all_done_d;
    logic        launch;
    logic        final_beat;
    logic [7:0]  last_beat;

    always_comb begin
        launch = (state_q == FEED_ARM) && enable && buffer_ready && !all_done_q &&
                 ((iLs == ILS_R23) || (iLs == ILS_R78));
        last_beat  = (ils_q == ILS_R23) ? 8'(3 * SUB_LEN + LONG_LEN - 1) : 8'(3 * SUB_LEN - 1);
        all_done_d = all_done_q || (decode_valid_cnt == 3'(BLK_NUM - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FEED_IDLE;
            ils_q   <= 3'd0;
        end else begin
            case (state_q)
                FEED_IDLE: state_q <= FEED_ARM;
                FEED_ARM: begin
                    if (launch) begin
                        state_q <= FEED_PRE;
                        ils_q   <= iLs;
                    end
                end
                FEED_PRE:    state_q <= FEED_STREAM;
                FEED_STREAM: if (final_beat) state_q <= FEED_GAP;
                FEED_GAP:    state_q <= FEED_ARM;
                default:     state_q <= FEED_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) all_done_q <= 1'b0;
        else     all_done_q <= all_done_d;
    end

    assign all_done = all_done_q;

    feed_beat_gen #(
        .SUB_LEN (SUB_LEN),
        .ADDR_W  (ADDR_W)
    ) u_beat_gen (
        .clk          (clk),
        .rst          (rst),
        .run          (state_q == FEED_STREAM),
        .last_beat    (last_beat),
        .final_beat   (final_beat),
        .rom_addr     (rom_addr),
        .buffer_valid (buffer_valid),
        .buffer_start (buffer_start),
        .buffer_last  (buffer_last),
        .sub_x        (APPmsg_ini_sub_x)
    );

`ifdef APPMSG_FEED_FRAMECNT_EN
    logic [7:0] frames_q, frames_d;

    // Counted on the edge that raises buffer_last, so both change together.
    always_comb frames_d = final_beat ? frames_q + 8'd1 : frames_q;

    always_ff @(posedge clk) begin
        if (rst) frames_q <= 8'd0;
        else     frames_q <= frames_d;
    end

    assign frames_sent = frames_q;
`else
    assign frames_sent = 8'd0;
`endif

endmodule

// File: tb/tb_appmsg_feed_ctrl.sv
// Directed/randomised bench for appmsg_feed_ctrl; expected beats come from
// frame-level arithmetic (length, beat/16, next-beat block index).
`timescale 1ns/1ps
module tb_appmsg_feed_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [2:0] iLs;
    logic       buffer_ready;
    logic [2:0] decode_valid_cnt;
    logic [1:0] rom_addr;
    logic       buffer_valid;
    logic       buffer_start;
    logic       buffer_last;
    logic [1:0] sub_x;
    logic       all_done;
    logic [7:0] frames_sent;

    int errors = 0;
    int checks = 0;
    int exp_frames = 0;

    always #5 clk = ~clk;

    appmsg_feed_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .iLs              (iLs),
        .buffer_ready     (buffer_ready),
        .decode_valid_cnt (decode_valid_cnt),
        .rom_addr         (rom_addr),
        .buffer_valid     (buffer_valid),
        .buffer_start     (buffer_start),
        .buffer_last      (buffer_last),
        .APPmsg_ini_sub_x (sub_x),
        .all_done         (all_done),
        .frames_sent      (frames_sent)
    );

    function automatic int frame_len(input int ils);
        return (ils == 1) ? 176 : 48;
    endfunction

    function automatic int sub_of(input int k);
        return (k / 16 > 3) ? 3 : k / 16;
    endfunction

    function automatic int addr_for(input int k, input int len);
        return (k + 1 < len) ? sub_of(k + 1) : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int limit, input string tag);
        int n;
        n = 0;
        while (buffer_start !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_seen"}, buffer_start, 1);
    endtask

    // Called at the negedge showing beat 0; returns at the negedge after the frame.
    task automatic stream_frame(input int len, input int drop_at, input int ils_at,
                                input int done_at, input int rst_at);
        for (int k = 0; k < len; k++) begin
            chk("valid", buffer_valid, 1);
            chk("start", buffer_start, 32'(k == 0));
            chk("last", buffer_last, 32'(k == len - 1));
            chk("sub_x", sub_x, sub_of(k));
            chk("rom_addr", rom_addr, addr_for(k, len));
            if (drop_at >= 0 && k == drop_at) buffer_ready = 1'b0;
            if (ils_at >= 0 && k == ils_at) iLs = 3'($urandom_range(0, 7));
            if (done_at >= 0 && k == done_at) begin
                chk("all_done_pre", all_done, 0);
                decode_valid_cnt = 3'd7;
            end
            if (done_at >= 0 && k == done_at + 1) begin
                chk("all_done_set", all_done, 1);
                decode_valid_cnt = 3'($urandom_range(0, 6));
            end
            if (rst_at >= 0 && k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_valid", buffer_valid, 0);
                chk("rst_start", buffer_start, 0);
                chk("rst_last", buffer_last, 0);
                chk("rst_sub_x", sub_x, 0);
                chk("rst_rom_addr", rom_addr, 0);
                chk("rst_frames", frames_sent, 0);
                rst = 1'b0;
                exp_frames = 0;
                return;
            end
            if (k == len - 1) exp_frames++;
            @(negedge clk);
        end
        chk("valid_drop", buffer_valid, 0);
        chk("last_drop", buffer_last, 0);
    endtask

    function automatic int exp_count();
`ifdef APPMSG_FEED_FRAMECNT_EN
        return exp_frames % 256;
`else
        return 0;
`endif
    endfunction

    int ils, len, drop, ilsat, cnt;

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        buffer_ready = 1'b0;
        iLs = 3'd2;
        decode_valid_cnt = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_valid", buffer_valid, 0);
        chk("reset_start", buffer_start, 0);
        chk("reset_last", buffer_last, 0);
        chk("reset_sub_x", sub_x, 0);
        chk("reset_rom_addr", rom_addr, 0);
        chk("reset_all_done", all_done, 0);
        chk("reset_frames", frames_sent, 0);
        rst = 1'b0;

        // Random frames with random mid-frame ready drops and iLs changes.
        for (int f = 0; f < 6; f++) begin
            ils = int'($urandom_range(1, 2));
            len = frame_len(ils);
            drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, len - 1)) : -1;
            if (f == 0) drop = 20;
            ilsat = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1;
            iLs = 3'(ils);
            decode_valid_cnt = 3'($urandom_range(0, 6));
            if (buffer_ready == 1'b0) begin
                repeat ($urandom_range(1, 8)) begin
                    @(negedge clk);
                    chk("held_no_valid", buffer_valid, 0);
                end
                buffer_ready = 1'b1;
                @(negedge clk);
                chk("latency_e1", buffer_start, 0);
                @(negedge clk);
                chk("latency_e2", buffer_start, 0);
                @(negedge clk);
                chk("latency_e3", buffer_start, 1);
            end
            wait_start(50, "frame");
            stream_frame(len, drop, ilsat, -1, -1);
        end
        chk("frames_sent_a", frames_sent, exp_count());

        // Reset at beat 30 of a 7/8 frame, then a clean restart.
        iLs = 3'd2;
        buffer_ready = 1'b1;
        wait_start(50, "pre_rst");
        stream_frame(48, -1, -1, -1, 30);
        wait_start(50, "post_rst");
        stream_frame(48, -1, -1, -1, -1);
        chk("frames_sent_b", frames_sent, exp_count());

        // Unsupported rate never launches.
        iLs = 3'd3;
        cnt = 0;
        repeat (500) begin
            @(negedge clk);
            if (buffer_valid === 1'b1) cnt++;
        end
        chk("ils3_no_valid", cnt, 0);

        // Final block reported mid-frame: frame finishes, nothing follows.
        iLs = 3'd1;
        wait_start(50, "done_frame");
        stream_frame(176, -1, -1, 10, -1);
        cnt = 0;
        repeat (500) begin
            @(negedge clk);
            if (buffer_start === 1'b1) cnt++;
        end
        chk("done_no_start", cnt, 0);
        chk("done_sticky", all_done, 1);
        chk("frames_sent_c", frames_sent, exp_count());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
